// File: rtl/store_trace_checker.sv
// store_trace_checker: compares the core's store stream against an expected sequence and
// reports a sticky pass/fail/timeout verdict within a bounded number of cycles.
module store_trace_checker #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32,
   parameter int NUM_CHECKS = 4,
   parameter logic [NUM_CHECKS*ADDR_W-1:0] EXP_ADDR = {NUM_CHECKS{ADDR_W'(32'h64)}},
   parameter logic [NUM_CHECKS*DATA_W-1:0] EXP_DATA = {NUM_CHECKS{DATA_W'(32'd25)}},
   parameter bit FILTERED = 1'b0,
   parameter logic [ADDR_W-1:0] WIN_LO = '0,
   parameter logic [ADDR_W-1:0] WIN_HI = ADDR_W'(32'hFFFF),
   parameter int TIMEOUT = 30
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              MemWrite,
   input  logic [ADDR_W-1:0] DataAdr,
   input  logic [DATA_W-1:0] WriteData,
   output logic              done,
   output logic              pass,
   output logic              fail,
   output logic              timeout,
   output logic [5:0]        chk_idx,
   output logic [15:0]       cyc_count,
   output logic [ADDR_W-1:0] bad_addr,
   output logic [DATA_W-1:0] bad_data
);
   if (NUM_CHECKS < 1 || NUM_CHECKS > 64) begin : gBadNum
      $error("store_trace_checker: NUM_CHECKS must be 1..64");
   end
   if (TIMEOUT < 1) begin : gBadTimeout
      $error("store_trace_checker: TIMEOUT must be >= 1");
   end
   typedef enum logic [1:0] {RUN, PASS, FAIL, TMO} stateT;
   localparam logic [5:0] LAST = 6'(NUM_CHECKS - 1);
   localparam logic [ADDR_W-1:0] WIN_SPAN = WIN_HI - WIN_LO;
   stateT state, stateNext;
   logic [5:0] idxNext;
   logic [15:0] cycNext;
   logic [ADDR_W-1:0] badAdrNext, expAdr, winOff;
   logic [DATA_W-1:0] badDatNext, expDat;
   logic qual, hit;
   // Offset-from-low compare covers both window bounds with one unsigned test.
   assign winOff = DataAdr - WIN_LO;
   assign qual = MemWrite && (!FILTERED || winOff <= WIN_SPAN);
   assign expAdr = EXP_ADDR[int'(chk_idx)*ADDR_W +: ADDR_W];
   assign expDat = EXP_DATA[int'(chk_idx)*DATA_W +: DATA_W];
   assign hit = DataAdr == expAdr && WriteData == expDat;
   assign pass = state == PASS;
   assign fail = state == FAIL;
   assign timeout = state == TMO;
   assign done = state != RUN;
   always_comb begin
      stateNext = state;
      idxNext = chk_idx;
      cycNext = cyc_count;
      badAdrNext = bad_addr;
      badDatNext = bad_data;
      if (state == RUN) begin
         cycNext = (cyc_count == 16'hFFFF) ? cyc_count : cyc_count + 16'd1;
         if (qual && hit) begin
            idxNext = chk_idx + 6'd1;
            stateNext = (chk_idx == LAST) ? PASS : RUN;
         end else if (qual) begin
            stateNext = FAIL;
            badAdrNext = DataAdr;
            badDatNext = WriteData;
         end
         // A store verdict on the same edge outranks the timeout.
         if (stateNext == RUN && cycNext == 16'(TIMEOUT)) stateNext = TMO;
      end
   end
   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= RUN;
         chk_idx <= '0;
         cyc_count <= '0;
         bad_addr <= '0;
         bad_data <= '0;
      end else begin
         state <= stateNext;
         chk_idx <= idxNext;
         cyc_count <= cycNext;
         bad_addr <= badAdrNext;
         bad_data <= badDatNext;
      end
   end
endmodule

// File: tb/tb_store_trace_checker.sv
// tb_store_trace_checker: directed spec scenarios plus random stores against a queue-style model.
module tb_store_trace_checker;
   logic clk = 1'b0;
   logic reset = 1'b0;
   logic memWrite = 1'b0;
   logic [31:0] dataAdr = '0;
   logic [31:0] writeData = '0;
   logic oDone[2], oPass[2], oFail[2], oTmo[2];
   logic [5:0] oIdx[2];
   logic [15:0] oCyc[2];
   logic [31:0] oBadA[2], oBadD[2];
   logic [89:0] dVec[2];
   int checks = 0;
   int failures = 0;
   logic [31:0] expA[2][4] = '{'{32'h64, 32'h64, 32'h64, 32'h64}, '{32'h60, 32'h64, 32'h68, 32'h6C}};
   logic [31:0] expD[2][4] = '{'{32'd25, 32'd25, 32'd25, 32'd25}, '{32'd11, 32'd22, 32'd33, 32'd44}};
   int mIdx[2] = '{0, 0};
   int mVer[2] = '{0, 0};
   int mCyc[2] = '{0, 0};
   logic [31:0] mBadA[2] = '{0, 0};
   logic [31:0] mBadD[2] = '{0, 0};

   always #5 clk = ~clk;

   store_trace_checker dutA (
      .clk(clk), .reset(reset), .MemWrite(memWrite), .DataAdr(dataAdr), .WriteData(writeData),
      .done(oDone[0]), .pass(oPass[0]), .fail(oFail[0]), .timeout(oTmo[0]), .chk_idx(oIdx[0]),
      .cyc_count(oCyc[0]), .bad_addr(oBadA[0]), .bad_data(oBadD[0]));

   store_trace_checker #(
      .EXP_ADDR({32'h6C, 32'h68, 32'h64, 32'h60}),
      .EXP_DATA({32'd44, 32'd33, 32'd22, 32'd11}),
      .FILTERED(1'b1), .WIN_LO(32'h60), .WIN_HI(32'h6F)
   ) dutB (
      .clk(clk), .reset(reset), .MemWrite(memWrite), .DataAdr(dataAdr), .WriteData(writeData),
      .done(oDone[1]), .pass(oPass[1]), .fail(oFail[1]), .timeout(oTmo[1]), .chk_idx(oIdx[1]),
      .cyc_count(oCyc[1]), .bad_addr(oBadA[1]), .bad_data(oBadD[1]));

   for (genvar k = 0; k < 2; k++) begin : gVec
      assign dVec[k] = {oDone[k], oPass[k], oFail[k], oTmo[k], oIdx[k], oCyc[k], oBadA[k], oBadD[k]};
   end

   // Verdict model: 0 running, 1 pass, 2 fail, 3 timeout.
   task automatic modelStep();
      for (int k = 0; k < 2; k++) begin
         if (!reset) begin
            mIdx[k] = 0; mVer[k] = 0; mCyc[k] = 0; mBadA[k] = 0; mBadD[k] = 0;
         end else if (mVer[k] == 0) begin
            bit q = memWrite && (k == 0 || (dataAdr >= 32'h60 && dataAdr <= 32'h6F));
            mCyc[k] = (mCyc[k] < 65535) ? mCyc[k] + 1 : 65535;
            if (q && dataAdr == expA[k][mIdx[k]] && writeData == expD[k][mIdx[k]]) begin
               mIdx[k]++;
               if (mIdx[k] == 4) mVer[k] = 1;
            end else if (q) begin
               mVer[k] = 2; mBadA[k] = dataAdr; mBadD[k] = writeData;
            end
            if (mVer[k] == 0 && mCyc[k] == 30) mVer[k] = 3;
         end
      end
   endtask

   function automatic logic [89:0] mVec(int k);
      return {mVer[k] != 0, mVer[k] == 1, mVer[k] == 2, mVer[k] == 3, 6'(mIdx[k]), 16'(mCyc[k]), mBadA[k], mBadD[k]};
   endfunction

   task automatic tick();
      @(posedge clk);
      modelStep();
      #1;
   endtask

   task automatic doReset();
      reset = 1'b0; memWrite = 1'b0; dataAdr = '0; writeData = '0;
      tick(); tick();
      reset = 1'b1;
   endtask

   task automatic store(input logic [31:0] a, input logic [31:0] d);
      memWrite = 1'b1; dataAdr = a; writeData = d;
      tick();
      memWrite = 1'b0;
   endtask

   task automatic test_reset();
      doReset();
      for (int k = 0; k < 2; k++) begin
         checks++;
         if (dVec[k] !== 90'd0) begin failures++; $display("FAIL reset dut%0d got=%h want=0", k, dVec[k]); end
      end
   endtask

   task automatic test_pass();
      logic [89:0] want = {1'b1, 1'b1, 1'b0, 1'b0, 6'd4, 16'd12, 32'd0, 32'd0};
      doReset();
      for (int c = 1; c <= 14; c++) begin
         if (c == 12) begin
            checks++;
            if (oDone[0] !== 1'b0 || oIdx[0] !== 6'd3) begin failures++; $display("FAIL pass_pre got done=%b idx=%0d want done=0 idx=3", oDone[0], oIdx[0]); end
         end
         if (c inside {3, 5, 8, 12}) store(32'h64, 32'd25); else tick();
      end
      checks++;
      if (dVec[0] !== want) begin failures++; $display("FAIL pass got=%h want=%h", dVec[0], want); end
      checks++;
      if (dVec[1] !== mVec(1)) begin failures++; $display("FAIL pass_model dut1 got=%h want=%h", dVec[1], mVec(1)); end
   endtask

   task automatic test_fail();
      logic [89:0] want = {1'b1, 1'b0, 1'b1, 1'b0, 6'd1, 16'd2, 32'h64, 32'd24};
      doReset();
      store(32'h64, 32'd25);
      store(32'h64, 32'd24);
      tick();
      store(32'h64, 32'd25);
      store(32'h70, 32'd7);
      checks++;
      if (dVec[0] !== want) begin failures++; $display("FAIL mismatch got=%h want=%h", dVec[0], want); end
   endtask

   task automatic test_timeout();
      logic [89:0] want = {1'b1, 1'b0, 1'b0, 1'b1, 6'd0, 16'd30, 32'd0, 32'd0};
      doReset();
      repeat (29) tick();
      checks++;
      if (oDone[0] !== 1'b0 || oCyc[0] !== 16'd29) begin failures++; $display("FAIL timeout_pre got done=%b cyc=%0d want done=0 cyc=29", oDone[0], oCyc[0]); end
      repeat (6) tick();
      for (int k = 0; k < 2; k++) begin
         checks++;
         if (dVec[k] !== want) begin failures++; $display("FAIL timeout dut%0d got=%h want=%h", k, dVec[k], want); end
      end
   endtask

   task automatic test_filtered();
      logic [31:0] sa[7] = '{32'h200, 32'h60, 32'h200, 32'h64, 32'h200, 32'h68, 32'h6C};
      logic [31:0] sd[7] = '{32'd1, 32'd11, 32'd2, 32'd22, 32'd3, 32'd33, 32'd44};
      logic [89:0] wantB = {1'b1, 1'b1, 1'b0, 1'b0, 6'd4, 16'd13, 32'd0, 32'd0};
      logic [89:0] wantA = {1'b1, 1'b0, 1'b1, 1'b0, 6'd0, 16'd1, 32'h200, 32'd1};
      doReset();
      for (int i = 0; i < 7; i++) begin store(sa[i], sd[i]); tick(); end
      checks++;
      if (dVec[1] !== wantB) begin failures++; $display("FAIL filtered got=%h want=%h", dVec[1], wantB); end
      checks++;
      if (dVec[0] !== wantA) begin failures++; $display("FAIL strict_sees_all got=%h want=%h", dVec[0], wantA); end
   endtask

   task automatic test_timeout_race();
      logic [89:0] want = {1'b1, 1'b1, 1'b0, 1'b0, 6'd4, 16'd30, 32'd0, 32'd0};
      doReset();
      for (int c = 1; c <= 32; c++) begin
         if (c == 30) begin
            checks++;
            if (oDone[0] !== 1'b0 || oCyc[0] !== 16'd29) begin failures++; $display("FAIL race_pre got done=%b cyc=%0d want done=0 cyc=29", oDone[0], oCyc[0]); end
         end
         if (c inside {1, 2, 3, 30}) store(32'h64, 32'd25); else tick();
      end
      checks++;
      if (dVec[0] !== want) begin failures++; $display("FAIL race got=%h want=%h", dVec[0], want); end
   endtask

   task automatic test_back_to_back();
      logic [89:0] want = {1'b1, 1'b1, 1'b0, 1'b0, 6'd4, 16'd4, 32'd0, 32'd0};
      doReset();
      store(32'h64, 32'd25);
      store(32'h64, 32'd25);
      tick();
      reset = 1'b0;
      tick();
      checks++;
      if (dVec[0] !== 90'd0) begin failures++; $display("FAIL midreset got=%h want=0", dVec[0]); end
      reset = 1'b1;
      repeat (4) store(32'h64, 32'd25);
      tick();
      checks++;
      if (dVec[0] !== want) begin failures++; $display("FAIL rerun got=%h want=%h", dVec[0], want); end
   endtask

   task automatic test_random();
      for (int r = 0; r < 25; r++) begin
         doReset();
         for (int c = 0; c < 40; c++) begin
            int sel = $urandom_range(0, 3);
            bit good = $urandom_range(0, 3) != 0;
            memWrite = $urandom_range(0, 1);
            dataAdr = sel == 0 ? 32'h64 : sel == 1 ? expA[1][mIdx[1] % 4] : sel == 2 ? 32'h200 : $urandom_range(32'h50, 32'h7F);
            writeData = !good ? 32'd24 : sel == 0 ? 32'd25 : expD[1][mIdx[1] % 4];
            if (!memWrite) begin dataAdr = 'x; writeData = 'x; end
            tick();
            for (int k = 0; k < 2; k++) begin
               checks++;
               if (dVec[k] !== mVec(k)) begin failures++; $display("FAIL random run%0d cyc%0d dut%0d got=%h want=%h", r, c, k, dVec[k], mVec(k)); end
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_pass();
      test_fail();
      test_timeout();
      test_filtered();
      test_timeout_race();
      test_back_to_back();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
